// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run sequencer.
package sim_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RST_HOLD = 3'd0;
  localparam state_t INIT     = 3'd1;
  localparam state_t RUN      = 3'd2;
  localparam state_t DRAIN    = 3'd3;
  localparam state_t DONE     = 3'd4;

  typedef logic [1:0] status_t;

  localparam status_t ST_RUNNING = 2'd0;
  localparam status_t ST_PASS    = 2'd1;
  localparam status_t ST_BADTRAP = 2'd2;
  localparam status_t ST_TIMEOUT = 2'd3;

  localparam logic [63:0] TRAP_CONTINUE = 64'd0;
  localparam logic [63:0] TRAP_GOOD     = 64'd1;

  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (v == 64'hFFFF_FFFF_FFFF_FFFF) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Host-model handshake bundle: init/step requests and the UART sink.
interface sim_run_ctrl_if #(
  parameter int unsigned CODE_W = 64
);
  logic              init_req;
  logic              init_ack;
  logic              step_req;
  logic              step_ack;
  logic [CODE_W-1:0] step_code;
  logic              uart_out_valid;
  logic              uart_out_ready;
  logic [7:0]        uart_out_ch;

  modport master (
    output init_req, step_req, uart_out_valid, uart_out_ch,
    input  init_ack, step_ack, step_code, uart_out_ready
  );

  modport slave (
    input  init_req, step_req, uart_out_valid, uart_out_ch,
    output init_ack, step_ack, step_code, uart_out_ready
  );
endinterface

// File: rtl/sim_uart_fifo.sv
// Synchronous FIFO with a registered head; pushes into a full FIFO are dropped
// unless a pop happens in the same cycle.
module sim_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] head_r;
  logic             do_pop_s;
  logic             do_push_s;
  logic [AW-1:0]    rd_next_s;

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {CW{1'b0}});
  assign head  = head_r;

  // Qualify pop/push; a full FIFO only accepts a push that is paired with a pop
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    rd_next_s = rd_ptr_r + PTR_ONE;
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // The head follows the next-oldest entry, or the incoming char when it becomes the only one
      if (do_pop_s) begin
        if (count_r == CNT_ONE) begin
          if (do_push_s) begin
            head_r <= din;
          end
        end else begin
          head_r <= mem_r[rd_next_s];
        end
      end else if (do_push_s && empty) begin
        head_r <= din;
      end
    end
  end
endmodule

// File: rtl/sim_run_ctrl.sv
// Run sequencer: DUT reset window, one-shot init, per-cycle steps, trap/timeout
// termination, log window gating and buffered UART forwarding to the host.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 50,
  parameter int unsigned UART_DEPTH   = 16,
  parameter int unsigned CODE_W       = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [63:0]         cfg_max_cycles,
  input  logic [63:0]         cfg_log_begin,
  input  logic [63:0]         cfg_log_end,
  output logic                dut_reset,
  sim_run_ctrl_if.master      host,
  input  logic                dut_uart_valid,
  input  logic [7:0]          dut_uart_ch,
  output logic                log_enable,
  output logic [63:0]         cycle_cnt,
  output logic [1:0]          status,
  output logic [CODE_W-1:0]   exit_code,
  output logic                uart_overflow,
  output logic                done
);
  localparam logic [9:0] HOLD_LAST = 10'(RESET_CYCLES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [9:0]        hold_cnt_r;
  logic [63:0]       cycle_cnt_r;
  status_t           status_r;
  logic [CODE_W-1:0] exit_code_r;
  logic              done_r;
  logic              overflow_r;
  logic              trap_s;
  logic              timeout_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [7:0]        fifo_head_s;
  logic              dut_reset_s;

  assign dut_reset_s = (state_r == RST_HOLD);
  assign push_s      = dut_uart_valid && !dut_reset_s && ((state_r == RUN) || (state_r == DRAIN));
  assign pop_s       = !fifo_empty_s && host.uart_out_ready;

  sim_uart_fifo #(
    .DEPTH (UART_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (dut_uart_ch),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Terminating conditions, only meaningful while running
  always_comb begin
    trap_s    = 1'b0;
    timeout_s = 1'b0;
    if (state_r == RUN) begin
      trap_s    = host.step_ack && (host.step_code != CODE_W'(TRAP_CONTINUE));
      timeout_s = (cfg_max_cycles != 64'd0) && (cycle_cnt_r == cfg_max_cycles - 64'd1);
    end else begin
      trap_s    = 1'b0;
      timeout_s = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      RST_HOLD: if (hold_cnt_r == HOLD_LAST) state_s = INIT;  else state_s = RST_HOLD;
      INIT:     if (host.init_ack)           state_s = RUN;   else state_s = INIT;
      RUN:      if (trap_s || timeout_s)     state_s = DRAIN; else state_s = RUN;
      DRAIN:    if (fifo_empty_s && !push_s) state_s = DONE;  else state_s = DRAIN;
      DONE:     state_s = DONE;
      default:  state_s = RST_HOLD;
    endcase
  end

  // State, counters and the latched run result
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= RST_HOLD;
      hold_cnt_r  <= 10'd0;
      cycle_cnt_r <= 64'd0;
      status_r    <= ST_RUNNING;
      exit_code_r <= {CODE_W{1'b0}};
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == RST_HOLD) begin
        hold_cnt_r <= hold_cnt_r + 10'd1;
      end
      if (state_r == RUN) begin
        cycle_cnt_r <= sat_inc64(cycle_cnt_r);
        // A trap in the same cycle as the limit takes precedence
        if (trap_s) begin
          exit_code_r <= host.step_code;
          status_r    <= (host.step_code == CODE_W'(TRAP_GOOD)) ? ST_PASS : ST_BADTRAP;
        end else if (timeout_s) begin
          exit_code_r <= CODE_W'(cycle_cnt_r + 64'd1);
          status_r    <= ST_TIMEOUT;
        end
      end
      if ((state_r == DRAIN) && (state_s == DONE)) begin
        done_r <= 1'b1;
      end
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign dut_reset           = dut_reset_s;
  assign host.init_req       = (state_r == INIT);
  assign host.step_req       = (state_r == RUN);
  assign host.uart_out_valid = !fifo_empty_s;
  assign host.uart_out_ch    = fifo_head_s;
  assign log_enable          = (state_r == RUN) && (cycle_cnt_r >= cfg_log_begin)
                               && (cycle_cnt_r < cfg_log_end);
  assign cycle_cnt           = cycle_cnt_r;
  assign status              = status_r;
  assign exit_code           = exit_code_r;
  assign uart_overflow       = overflow_r;
  assign done                = done_r;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: directed table, corner sequences and
// randomized runs scored against a run-outcome model and a UART queue model.
module tb_sim_run_ctrl;
  localparam int unsigned RC    = 4;
  localparam int unsigned DEPTH = 4;
  localparam longint unsigned NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] cfg_max_cycles = 64'd0;
  logic [63:0] cfg_log_begin  = 64'd0;
  logic [63:0] cfg_log_end    = 64'd0;
  logic        dut_reset;
  logic        dut_uart_valid = 1'b0;
  logic [7:0]  dut_uart_ch    = 8'd0;
  logic        log_enable;
  logic [63:0] cycle_cnt;
  logic [1:0]  status;
  logic [63:0] exit_code;
  logic        uart_overflow;
  logic        done;

  sim_run_ctrl_if #(.CODE_W(64)) hif ();

  sim_run_ctrl #(.RESET_CYCLES(RC), .UART_DEPTH(DEPTH), .CODE_W(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_max_cycles (cfg_max_cycles),
    .cfg_log_begin  (cfg_log_begin),
    .cfg_log_end    (cfg_log_end),
    .dut_reset      (dut_reset),
    .host           (hif),
    .dut_uart_valid (dut_uart_valid),
    .dut_uart_ch    (dut_uart_ch),
    .log_enable     (log_enable),
    .cycle_cnt      (cycle_cnt),
    .status         (status),
    .exit_code      (exit_code),
    .uart_overflow  (uart_overflow),
    .done           (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned maxc, trap_at, code, lb, le;
    int              iw;
    logic [1:0]      st;
    longint unsigned ex, cyc, logc;
  } vec_t;

  vec_t            tbl [7];
  int              checks = 0;
  int              errors = 0;
  byte unsigned    q [$];
  bit              ovf_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dut_reset"}, 64'(dut_reset), 64'd1);
    chk({tag, "_init_req"},  64'(hif.init_req), 64'd0);
    chk({tag, "_step_req"},  64'(hif.step_req), 64'd0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    chk({tag, "_status"},    64'(status), 64'd0);
    chk({tag, "_exit_code"}, exit_code, 64'd0);
    chk({tag, "_overflow"},  64'(uart_overflow), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_log"},       64'(log_enable), 64'd0);
    chk({tag, "_uart_valid"}, 64'(hif.uart_out_valid), 64'd0);
  endtask

  // Compare UART outputs with the queue model, then apply this cycle's inputs to both
  task automatic uart_cycle(input bit active, input bit v, input byte unsigned ch, input bit rdy);
    bit pop_ok;
    bit push_ok;
    chk("uart_valid", 64'(hif.uart_out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("uart_ch", 64'(hif.uart_out_ch), 64'(q[0]));
    chk("uart_overflow", 64'(uart_overflow), 64'(ovf_exp));
    dut_uart_valid     = v;
    dut_uart_ch        = ch;
    hif.uart_out_ready = rdy;
    pop_ok  = (q.size() != 0) && rdy;
    push_ok = v && active && ((q.size() < DEPTH) || pop_ok);
    if (v && active && !push_ok) ovf_exp = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(ch);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset              = 1'b0;
    hif.init_ack       = 1'b0;
    hif.step_ack       = 1'b0;
    hif.step_code      = 64'd0;
    hif.uart_out_ready = 1'b0;
    dut_uart_valid     = 1'b0;
    q.delete();
    ovf_exp = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_values("rst");
  endtask

  task automatic release_and_init(input int init_wait);
    int k = 0;
    reset = 1'b1;
    while (!hif.init_req && k < 12) begin
      chk("dut_reset_hold", 64'(dut_reset), 64'd1);
      @(negedge clock);
      k++;
    end
    chk("init_latency", 64'(k), 64'(RC));
    chk("dut_reset_released", 64'(dut_reset), 64'd0);
    for (int i = 0; i < init_wait; i++) begin
      chk("init_req_held", 64'(hif.init_req), 64'd1);
      chk("step_req_in_init", 64'(hif.step_req), 64'd0);
      @(negedge clock);
    end
    hif.init_ack = 1'b1;
    @(negedge clock);
    hif.init_ack = 1'b0;
    chk("init_req_drop", 64'(hif.init_req), 64'd0);
  endtask

  task automatic run_one(input vec_t v, input bit rnd);
    longint unsigned n = 0;
    longint unsigned logc = 0;
    bit              term = 1'b0;
    int              guard = 0;
    do_reset();
    cfg_max_cycles = v.maxc;
    cfg_log_begin  = v.lb;
    cfg_log_end    = v.le;
    release_and_init(v.iw);
    while (!term && n < 1200) begin
      chk("step_req_run", 64'(hif.step_req), 64'd1);
      chk("cycle_cnt", cycle_cnt, n);
      chk("status_running", 64'(status), 64'd0);
      chk("log_enable", 64'(log_enable), 64'((v.lb <= n) && (n < v.le)));
      if (log_enable) logc++;
      if (n == v.trap_at) begin
        hif.step_ack = 1'b1; hif.step_code = v.code;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        hif.step_ack = 1'b0; hif.step_code = {$urandom, $urandom};
      end else begin
        hif.step_ack = 1'b1; hif.step_code = 64'd0;
      end
      term = (n == v.trap_at) || ((v.maxc != 0) && (n == v.maxc - 1));
      uart_cycle(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom_range(0, 255)),
                 rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clock);
      n++;
    end
    chk("run_terminates", 64'(term), 64'd1);
    hif.step_ack  = 1'b0;
    hif.step_code = 64'd0;
    chk("step_req_drop", 64'(hif.step_req), 64'd0);
    chk("status", 64'(status), 64'(v.st));
    chk("exit_code", exit_code, v.ex);
    chk("final_cycles", cycle_cnt, v.cyc);
    chk("log_off_drain", 64'(log_enable), 64'd0);
    chk("log_count", logc, v.logc);
    while (!done && guard < 40) begin
      uart_cycle(1'b1, 1'b0, 8'd0, 1'b1);
      @(negedge clock);
      guard++;
    end
    chk("done", 64'(done), 64'd1);
    chk("drained", 64'(q.size()), 64'd0);
    chk("uart_idle", 64'(hif.uart_out_valid), 64'd0);
    repeat (3) @(negedge clock);
    chk("done_hold", 64'(done), 64'd1);
    chk("cycles_hold", cycle_cnt, v.cyc);
    chk("status_hold", 64'(status), 64'(v.st));
    chk("step_req_done", 64'(hif.step_req), 64'd0);
  endtask

  task automatic uart_directed();
    string        s_in  = "ABCDE";
    string        s_exp = "ABCD";
    byte unsigned got [$];
    int           guard = 0;
    do_reset();
    cfg_max_cycles = 64'd0; cfg_log_begin = 64'd0; cfg_log_end = 64'd0;
    release_and_init(0);
    for (int i = 0; i < 5; i++) begin
      hif.step_ack = 1'b0;
      uart_cycle(1'b1, 1'b1, s_in[i], 1'b0);
      @(negedge clock);
    end
    chk("uart_ovf_sticky", 64'(uart_overflow), 64'd1);
    chk("uart_full_valid", 64'(hif.uart_out_valid), 64'd1);
    chk("uart_head_A", 64'(hif.uart_out_ch), 64'h41);
    hif.step_ack = 1'b1; hif.step_code = 64'd1;
    uart_cycle(1'b1, 1'b0, 8'd0, 1'b0);
    @(negedge clock);
    hif.step_ack = 1'b0; hif.step_code = 64'd0;
    while (!done && guard < 20) begin
      if (hif.uart_out_valid) got.push_back(hif.uart_out_ch);
      uart_cycle(1'b1, 1'b0, 8'd0, 1'b1);
      @(negedge clock);
      guard++;
    end
    chk("uart_done", 64'(done), 64'd1);
    chk("uart_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("uart_order", 64'((i < got.size()) ? got[i] : 8'd0), 64'(s_exp[i]));
    end
    chk("uart_status", 64'(status), 64'd1);
    chk("uart_ovf_after", 64'(uart_overflow), 64'd1);
  endtask

  task automatic reset_mid_run();
    do_reset();
    cfg_max_cycles = 64'd0; cfg_log_begin = 64'd0; cfg_log_end = NONE;
    release_and_init(1);
    for (int i = 0; i < 7; i++) begin
      hif.step_ack = 1'b1; hif.step_code = 64'd0;
      uart_cycle(1'b1, 1'b1, 8'(8'h61 + i), 1'b0);
      @(negedge clock);
    end
    chk("mid_overflow", 64'(uart_overflow), 64'd1);
    chk("mid_log", 64'(log_enable), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_values("midrst");
    hif.step_ack = 1'b0;
  endtask

  initial begin
    longint unsigned maxc, trap_at, code, lb, le;
    vec_t            rv;
    hif.init_ack = 1'b0; hif.step_ack = 1'b0; hif.step_code = 64'd0; hif.uart_out_ready = 1'b0;

    //             maxc    trap   code                    lb     le    iw  st     ex                     cyc     log
    tbl[0] = '{64'd0,  64'd3,    64'd1,                 64'd0, NONE,  3, 2'd1, 64'd1,                 64'd4,    64'd4};
    tbl[1] = '{64'd0,  64'd2,    64'h2A,                64'd1, 64'd3, 0, 2'd2, 64'h2A,                64'd3,    64'd2};
    tbl[2] = '{64'd10, 64'd9,    64'd1,                 64'd0, 64'd0, 1, 2'd1, 64'd1,                 64'd10,   64'd0};
    tbl[3] = '{64'd10, NONE,     64'd0,                 64'd5, 64'd8, 0, 2'd3, 64'd10,                64'd10,   64'd3};
    tbl[4] = '{64'd0,  64'd1000, 64'd5,                 64'd0, 64'd0, 0, 2'd2, 64'd5,                 64'd1001, 64'd0};
    tbl[5] = '{64'd1,  NONE,     64'd0,                 64'd0, 64'd1, 2, 2'd3, 64'd1,                 64'd1,    64'd1};
    tbl[6] = '{64'd0,  64'd0,    64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'd3, 0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0};

    for (int i = 0; i < 7; i++) run_one(tbl[i], 1'b0);

    uart_directed();
    reset_mid_run();

    for (int r = 0; r < 25; r++) begin
      maxc    = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 30));
      trap_at = 64'($urandom_range(0, 35));
      code    = ($urandom_range(0, 2) == 0) ? 64'd1 : {$urandom, $urandom};
      if (code < 64'd2) code = 64'd2;
      lb = 64'($urandom_range(0, 20));
      le = 64'($urandom_range(0, 25));
      rv.maxc = maxc; rv.trap_at = trap_at; rv.code = code; rv.lb = lb; rv.le = le;
      rv.iw = int'($urandom_range(0, 3));
      if ((maxc != 0) && (maxc - 1 < trap_at)) begin
        rv.st = 2'd3; rv.ex = maxc; rv.cyc = maxc;
      end else begin
        rv.st = (code == 64'd1) ? 2'd1 : 2'd2; rv.ex = code; rv.cyc = trap_at + 1;
      end
      rv.logc = 0;
      for (longint unsigned c = 0; c < rv.cyc; c++) begin
        if ((lb <= c) && (c < le)) rv.logc++;
      end
      run_one(rv, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Run sequencer for the simulation top.
- Holds DUT reset for a programmable window, then issues a one-shot init handshake to the host model, then issues one step handshake per cycle.
- Interprets returned trap codes, enforces the max-cycle limit, gates the log window, and buffers DUT UART output to the host sink.
- Replaces the free-running init/step/trap logic in the test top with a single verifiable FSM.

Parameters:
- RESET_CYCLES, 50: cycles DUT reset is held after controller reset release; legal range 1..1023.
- UART_DEPTH, 16: UART FIFO depth in entries; power of 2, at least 2.
- CODE_W, 64: trap code width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- cfg_max_cycles  in  64  RUN-cycle limit; 0 means no limit.
- cfg_log_begin  in  64  log window start cycle, inclusive.
- cfg_log_end  in  64  log window end cycle, exclusive.
- dut_reset  out  1  active-high reset driven to the DUT.
- init_req  out  1  init request to the host model.
- init_ack  in  1  init done.
- step_req  out  1  step request.
- step_ack  in  1  step done; step_code valid in the same cycle.
- step_code  in  CODE_W  0 = continue, 1 = good trap, greater than 1 = bad trap.
- dut_uart_valid  in  1  DUT UART char strobe.
- dut_uart_ch  in  8  DUT UART char.
- uart_out_valid  out  1  host UART sink valid.
- uart_out_ready  in  1  host UART sink ready.
- uart_out_ch  out  8  host UART char.
- log_enable  out  1  cycle is inside the log window.
- cycle_cnt  out  64  count of RUN cycles.
- status  out  2  0 = running, 1 = pass, 2 = bad trap, 3 = timeout.
- exit_code  out  CODE_W  latched terminating code.
- uart_overflow  out  1  sticky; a char was dropped because the FIFO was full.
- done  out  1  run finished and UART drained.

Behaviour:
- Reset (reset == 0, sampled on clock):
  - State goes to RST_HOLD and the hold counter goes to 0.
  - Output reset values: dut_reset = 1, init_req = 0, step_req = 0, cycle_cnt = 0, status = 0, exit_code = 0, uart_overflow = 0, done = 0, log_enable = 0, uart_out_valid = 0.
  - The FIFO is flushed.
  - Reset asserted in any state aborts the run immediately; no outstanding handshake is honoured.
- States:
  - RST_HOLD: dut_reset = 1. Counter increments each cycle. When counter == RESET_CYCLES-1, go to INIT. dut_reset first reads 0 in the INIT cycle, so reset is held exactly RESET_CYCLES cycles.
  - INIT: init_req = 1, held level until init_ack is sampled high. Then go to RUN. init_req is 0 in the next cycle. init_ack outside INIT is ignored.
  - RUN: step_req = 1 whenever no completed step is pending. Each step_ack completes one step.
    - step_code == 0: stay in RUN.
    - step_code == 1: exit_code = 1, status = 1, go to DRAIN.
    - step_code > 1: exit_code = step_code, status = 2, go to DRAIN.
    - step_req drops to 0 in the cycle after the terminating ack.
  - RUN cycle counting: cycle_cnt increments on every clock spent in RUN, whether or not a step completes.
  - Timeout: if cfg_max_cycles != 0 and cycle_cnt == cfg_max_cycles-1 with no terminating ack that cycle, go to DRAIN with status = 3 and exit_code = cycle_cnt+1.
  - Simultaneous trap and timeout in the same cycle: the trap wins.
  - DRAIN: step_req = 0. When the FIFO is empty and no char is in flight, done = 1 and go to DONE.
  - DONE: terminal. All outputs are held; only reset leaves this state.
- log_enable:
  - Combinational: 1 when state == RUN and cfg_log_begin <= cycle_cnt < cfg_log_end.
  - If cfg_log_end <= cfg_log_begin, log_enable is always 0.
  - Compares are unsigned 64-bit.
- UART FIFO:
  - Push when dut_uart_valid && dut_reset == 0 && state is RUN or DRAIN.
  - Pop on uart_out_valid && uart_out_ready.
  - Full with a push and no same-cycle pop: the char is dropped and uart_overflow is set (sticky until reset).
  - Full with push and pop in the same cycle: both happen and there is no overflow.
  - uart_out_valid = !empty; uart_out_ch = head entry, driven from a register.
  - Pointers wrap modulo UART_DEPTH; a count register of width log2(UART_DEPTH)+1 distinguishes full from empty.
- cycle_cnt saturates at 2^64-1 and does not wrap.

Decomposition:
- Shared package sim_ctrl_pkg holds:
  - the state enum (RST_HOLD, INIT, RUN, DRAIN, DONE);
  - status codes: ST_RUNNING = 0, ST_PASS = 1, ST_BADTRAP = 2, ST_TIMEOUT = 3;
  - trap constants: TRAP_CONTINUE = 0, TRAP_GOOD = 1.
- One sub-module: sim_uart_fifo, a synchronous FIFO parameterised by DEPTH and WIDTH = 8. It exposes push, pop, full, empty and head, and drop-on-full is handled inside it.

Test Plan:
- Reset release with RESET_CYCLES = 4: dut_reset is high for exactly 4 cycles after reset goes high. init_req rises in cycle 5. init_ack at cycle 8 brings step_req high in cycle 9.
- Steps returning codes 0,0,0,1, acked every cycle: status = 1, exit_code = 1, step_req falls the next cycle, done = 1 once the FIFO is empty.
- Bad trap returning code 0x2A on step 3: status = 2, exit_code = 0x2A. Also apply code 1 in the same cycle the max-cycle limit hits: status = 1, confirming trap beats timeout.
- cfg_max_cycles = 10 with step_code always 0: status = 3 and exit_code = 10 after 10 RUN cycles. cfg_max_cycles = 0 with 1000 steps: never terminates.
- UART with UART_DEPTH = 4 and uart_out_ready = 0: push 'A','B','C','D','E'. The FIFO holds ABCD and uart_overflow = 1. Raising ready emits ABCD in order, then done = 1.
- Log window: cfg_log_begin = 5, cfg_log_end = 8 gives log_enable high exactly for cycle_cnt 5, 6, 7. cfg_log_begin = cfg_log_end = 0 keeps log_enable low throughout. Asserting reset mid-RUN returns all outputs to their reset values the next cycle.
